// File: rtl/ref_row_streamer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ref_row_streamer_pkg                                                       |
// | Shared geometry and state encoding for the reference-row streamer.         |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
package ref_row_streamer_pkg;

  localparam int PIX_W     = 8;   // bits per pixel
  localparam int NUM_PIXEL = 8;   // interpolated pixels per row
  localparam int TAPS      = 8;   // FIR tap count
  localparam int ROW_PIX   = NUM_PIXEL + TAPS - 1;  // 15 reference pixels per row
  localparam int ROWS      = ROW_PIX;               // square block
  localparam int WORD_PIX  = 8;                     // pixels per memory word
  // Worst-case offset (WORD_PIX-1) still has to fit the whole row.
  localparam int WORDS     = (ROW_PIX + WORD_PIX - 1 + WORD_PIX - 1) / WORD_PIX;
  localparam int WORD_W    = WORD_PIX * PIX_W;
  localparam int ROW_W     = ROW_PIX * PIX_W;

  localparam int XOFF_W    = 3;
  localparam int WCNT_W    = 2;
  localparam int RCNT_W    = 4;

  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(WORDS - 1);
  localparam logic [RCNT_W-1:0] LAST_ROW  = RCNT_W'(ROWS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_CAP  = 2'd2,
    ST_OUT  = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/ref_row_streamer_row_aligner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ref_row_streamer_row_aligner                                               |
// | Combinational funnel: selects ROW_PIX consecutive pixels starting at       |
// | x_off_i out of the concatenated word registers (word 0 lowest).            |
// | Ports: words_i  - WORDS*WORD_W bits of held word data                      |
// |        x_off_i  - pixel offset of the first output pixel                   |
// |        row_o    - aligned row, pixel i at bits [PIX_W*i +: PIX_W]          |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module ref_row_streamer_row_aligner
  import ref_row_streamer_pkg::*;
(
  input  logic [WORDS*WORD_W-1:0] words_i,
  input  logic [XOFF_W-1:0]       x_off_i,
  output logic [ROW_W-1:0]        row_o
);

  // One mux per output pixel; the largest index (ROW_PIX-1+7) stays inside
  // the word window because WORDS was sized for the worst-case offset.
  for (genvar i = 0; i < ROW_PIX; i++) begin : g_pix
    assign row_o[i*PIX_W +: PIX_W] = words_i[(i + int'(x_off_i))*PIX_W +: PIX_W];
  end

endmodule
`default_nettype wire

// File: rtl/ref_row_streamer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ref_row_streamer                                                           |
// | Fetches a ROWS x ROW_PIX reference block from word-organised memory and    |
// | streams one offset-aligned row per valid/ready handshake.                  |
// | Ports: clk, rst (sync, active-low)                                         |
// |        start_i/base_addr_i/x_off_i/stride_i - block request (IDLE only)    |
// |        mem_rd_en_o/mem_addr_o/mem_rdata_i   - word memory, 1-cycle latency |
// |        out_row_o/out_valid_o/out_ready_i/row_idx_o - row stream            |
// |        busy_o/done_o - block status, done is a one-cycle pulse             |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module ref_row_streamer
  import ref_row_streamer_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [ADDR_W-1:0]    base_addr_i,
  input  logic [XOFF_W-1:0]    x_off_i,
  input  logic [ADDR_W-1:0]    stride_i,
  output logic                 mem_rd_en_o,
  output logic [ADDR_W-1:0]    mem_addr_o,
  input  logic [WORD_W-1:0]    mem_rdata_i,
  output logic [ROW_W-1:0]     out_row_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [RCNT_W-1:0]    row_idx_o,
  output logic                 busy_o,
  output logic                 done_o
);

  state_e              state_q;
  logic [ADDR_W-1:0]   row_addr_q;
  logic [ADDR_W-1:0]   stride_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [XOFF_W-1:0]   x_off_q;
  logic [WCNT_W-1:0]   word_cnt_q;
  logic [RCNT_W-1:0]   row_cnt_q;
  logic                mem_rd_en_q;
  logic                out_valid_q;
  logic                busy_q;
  logic                done_q;
  logic [WORD_W-1:0]   word_q [WORDS];

  logic [ADDR_W-1:0]   row_addr_d;
  logic [WCNT_W-1:0]   cap_idx_d;
  logic                accept_d;
  logic [WORDS*WORD_W-1:0] words_flat;

  always_comb begin
    row_addr_d = row_addr_q + stride_q;   // modulo 2^ADDR_W, wrap is silent
    // Read data lags the request by one cycle, so the word landing now
    // belongs to the previous word index.
    cap_idx_d  = word_cnt_q - WCNT_W'(1);
    accept_d   = out_valid_q & out_ready_i;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      row_addr_q  <= '0;
      stride_q    <= '0;
      mem_addr_q  <= '0;
      x_off_q     <= '0;
      word_cnt_q  <= '0;
      row_cnt_q   <= '0;
      mem_rd_en_q <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      for (int w = 0; w < WORDS; w++) begin
        word_q[w] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            stride_q    <= stride_i;
            x_off_q     <= x_off_i;
            row_addr_q  <= base_addr_i;
            mem_addr_q  <= base_addr_i;
            row_cnt_q   <= '0;
            word_cnt_q  <= '0;
            busy_q      <= 1'b1;
            mem_rd_en_q <= 1'b1;
            state_q     <= ST_RD;
          end
        end
        ST_RD: begin
          if (word_cnt_q != '0) begin
            word_q[cap_idx_d] <= mem_rdata_i;
          end
          if (word_cnt_q == LAST_WORD) begin
            mem_rd_en_q <= 1'b0;
            state_q     <= ST_CAP;
          end else begin
            mem_addr_q <= mem_addr_q + ADDR_W'(1);
            word_cnt_q <= word_cnt_q + WCNT_W'(1);
          end
        end
        ST_CAP: begin
          // Last word of the row arrives here with no new request issued.
          word_q[WORDS-1] <= mem_rdata_i;
          out_valid_q     <= 1'b1;
          state_q         <= ST_OUT;
        end
        ST_OUT: begin
          if (accept_d) begin
            out_valid_q <= 1'b0;
            if (row_cnt_q == LAST_ROW) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              row_cnt_q   <= row_cnt_q + RCNT_W'(1);
              row_addr_q  <= row_addr_d;
              mem_addr_q  <= row_addr_d;
              word_cnt_q  <= '0;
              mem_rd_en_q <= 1'b1;
              state_q     <= ST_RD;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  for (genvar w = 0; w < WORDS; w++) begin : g_pack
    assign words_flat[w*WORD_W +: WORD_W] = word_q[w];
  end

  ref_row_streamer_row_aligner u_aligner (
    .words_i (words_flat),
    .x_off_i (x_off_q),
    .row_o   (out_row_o)
  );

  assign mem_rd_en_o = mem_rd_en_q;
  assign mem_addr_o  = mem_addr_q;
  assign out_valid_o = out_valid_q;
  assign row_idx_o   = row_cnt_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_ref_row_streamer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ref_row_streamer                                                        |
// | Self-checking bench: word memory model, row/address scoreboards, vector    |
// | table for block-level expectations and hand-written corner sequences.      |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_ref_row_streamer;
  import ref_row_streamer_pkg::*;

  localparam int AW = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start_i = 1'b0;
  logic [AW-1:0]     base_addr_i = '0;
  logic [XOFF_W-1:0] x_off_i = '0;
  logic [AW-1:0]     stride_i = '0;
  logic              mem_rd_en_o;
  logic [AW-1:0]     mem_addr_o;
  logic [WORD_W-1:0] mem_rdata_i = '0;
  logic [ROW_W-1:0]  out_row_o;
  logic              out_valid_o;
  logic              out_ready_i = 1'b1;
  logic [RCNT_W-1:0] row_idx_o;
  logic              busy_o;
  logic              done_o;

  ref_row_streamer #(.ADDR_W(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .x_off_i     (x_off_i),
    .stride_i    (stride_i),
    .mem_rd_en_o (mem_rd_en_o),
    .mem_addr_o  (mem_addr_o),
    .mem_rdata_i (mem_rdata_i),
    .out_row_o   (out_row_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .row_idx_o   (row_idx_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory: pixel k of word a is (8a+k) & 0xFF, one-cycle read latency.
  function automatic logic [WORD_W-1:0] mem_word(input logic [AW-1:0] a);
    logic [WORD_W-1:0] w;
    for (int k = 0; k < WORD_PIX; k++) w[k*PIX_W +: PIX_W] = 8'((8 * int'(a) + k) & 255);
    return w;
  endfunction

  always @(posedge clk) if (mem_rd_en_o) mem_rdata_i <= mem_word(mem_addr_o);

  function automatic logic [ROW_W-1:0] exp_row(input logic [AW-1:0] ra, input logic [XOFF_W-1:0] xo);
    logic [ROW_W-1:0] r;
    logic [AW-1:0]    wa;
    int               p;
    for (int j = 0; j < ROW_PIX; j++) begin
      p  = int'(xo) + j;
      wa = ra + AW'(p / 8);
      r[j*PIX_W +: PIX_W] = 8'((8 * int'(wa) + (p % 8)) & 255);
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [RCNT_W-1:0] idx;
    logic [ROW_W-1:0]  row;
  } row_t;

  row_t          row_q[$];
  logic [AW-1:0] addr_q[$];

  int            start_cyc = 0;
  int            first_valid_cyc = -1;
  int            done_cyc = -1;
  int            nreads = 0;
  logic [AW-1:0] rd_log [8];
  logic [7:0]    r0px = '0;
  logic [7:0]    r14px = '0;

  // Monitor: sampled 1 time unit after the falling edge.
  always @(negedge clk) begin
    #1;
    if (mem_rd_en_o) begin
      if (nreads < 8) rd_log[nreads] = mem_addr_o;
      nreads++;
      if (addr_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_read: addr %0h issued, none required", mem_addr_o);
      end else begin
        logic [AW-1:0] ea;
        ea = addr_q.pop_front();
        chk("rd_addr", 128'(mem_addr_o), 128'(ea));
      end
    end
    if (out_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc - start_cyc;
    if (done_o && done_cyc < 0) done_cyc = cyc - start_cyc;
    if (out_valid_o && out_ready_i) begin
      if (row_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_row: idx %0d delivered, none required", row_idx_o);
      end else begin
        row_t er;
        er = row_q.pop_front();
        chk("row_idx", 128'(row_idx_o), 128'(er.idx));
        chk("out_row", 128'(out_row_o), 128'(er.row));
        if (row_idx_o == 4'd0)  r0px  = out_row_o[7:0];
        if (row_idx_o == 4'd14) r14px = out_row_o[7:0];
      end
    end
  end

  task automatic run_block(input logic [AW-1:0] b, input logic [AW-1:0] s, input logic [XOFF_W-1:0] xo);
    logic [AW-1:0] ra;
    @(negedge clk);
    base_addr_i = b;
    stride_i    = s;
    x_off_i     = xo;
    start_i     = 1'b1;
    start_cyc   = cyc;
    first_valid_cyc = -1;
    done_cyc    = -1;
    nreads      = 0;
    for (int r = 0; r < ROWS; r++) begin
      ra = b + AW'(r) * s;
      row_q.push_back('{idx: RCNT_W'(r), row: exp_row(ra, xo)});
      for (int w = 0; w < WORDS; w++) addr_q.push_back(ra + AW'(w));
    end
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done_cyc < 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (done_cyc < 0) begin
      total++;
      bad++;
      $display("FAIL done_timeout: no done within %0d cycles", budget);
    end
    @(negedge clk);
    chk("rows_left", 128'(row_q.size()), 128'(0));
  endtask

  task automatic wait_row(input logic [RCNT_W-1:0] idx, input logic want_rd);
    int n;
    n = 0;
    while (!((want_rd ? mem_rd_en_o : out_valid_o) && row_idx_o == idx) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL row_wait_timeout: row %0d never reached", idx);
    end
  endtask

  typedef struct {
    logic [AW-1:0]     base;
    logic [AW-1:0]     stride;
    logic [XOFF_W-1:0] xo;
    logic [7:0]        px0;
    logic [7:0]        px14;
    logic [AW-1:0]     rd2;
    logic [AW-1:0]     rd3;
  } vec_t;

  vec_t vt [4];

  initial begin
    logic [ROW_W-1:0] held;

    vt[0] = '{base: 16'h0010, stride: 16'd4, xo: 3'd0, px0: 8'h80, px14: 8'h40, rd2: 16'h0012, rd3: 16'h0014};
    vt[1] = '{base: 16'h0010, stride: 16'd4, xo: 3'd5, px0: 8'h85, px14: 8'h45, rd2: 16'h0012, rd3: 16'h0014};
    vt[2] = '{base: 16'h0010, stride: 16'd4, xo: 3'd7, px0: 8'h87, px14: 8'h47, rd2: 16'h0012, rd3: 16'h0014};
    vt[3] = '{base: 16'hFFFF, stride: 16'd1, xo: 3'd0, px0: 8'hF8, px14: 8'h68, rd2: 16'h0001, rd3: 16'h0000};

    // Reset state
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rd_en",  128'(mem_rd_en_o), 128'(0));
    chk("rst_addr",   128'(mem_addr_o),  128'(0));
    chk("rst_row",    128'(out_row_o),   128'(0));
    chk("rst_valid",  128'(out_valid_o), 128'(0));
    chk("rst_idx",    128'(row_idx_o),   128'(0));
    chk("rst_busy",   128'(busy_o),      128'(0));
    chk("rst_done",   128'(done_o),      128'(0));
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven full blocks with out_ready held high
    for (int i = 0; i < 4; i++) begin
      run_block(vt[i].base, vt[i].stride, vt[i].xo);
      wait_done(200);
      chk("first_valid_cycle", 128'(first_valid_cyc), 128'(5));
      chk("done_cycle",        128'(done_cyc),        128'(76));
      chk("read_count",        128'(nreads),          128'(45));
      chk("row0_px0",          128'(r0px),            128'(vt[i].px0));
      chk("row14_px0",         128'(r14px),           128'(vt[i].px14));
      chk("read2_addr",        128'(rd_log[2]),       128'(vt[i].rd2));
      chk("read3_addr",        128'(rd_log[3]),       128'(vt[i].rd3));
      chk("busy_after",        128'(busy_o),          128'(0));
    end

    // Backpressure: three stalled cycles on row 2
    run_block(16'h0010, 16'd4, 3'd0);
    @(negedge clk);
    wait_row(4'd2, 1'b0);
    out_ready_i = 1'b0;
    held = out_row_o;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_row",   128'(out_row_o),   128'(held));
      chk("stall_idx",   128'(row_idx_o),   128'(2));
      chk("stall_valid", 128'(out_valid_o), 128'(1));
      chk("stall_rd_en", 128'(mem_rd_en_o), 128'(0));
    end
    out_ready_i = 1'b1;
    @(negedge clk);
    chk("post_stall_rd_en", 128'(mem_rd_en_o), 128'(1));
    chk("post_stall_idx",   128'(row_idx_o),   128'(3));
    wait_done(200);

    // Start during row 4 is ignored; reset during RD of row 6 aborts
    run_block(16'h0010, 16'd4, 3'd0);
    @(negedge clk);
    wait_row(4'd4, 1'b0);
    base_addr_i = 16'h0200;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    wait_row(4'd6, 1'b1);
    rst = 1'b0;
    #2;
    row_q.delete();
    addr_q.delete();
    @(negedge clk);
    chk("abort_rd_en", 128'(mem_rd_en_o), 128'(0));
    chk("abort_addr",  128'(mem_addr_o),  128'(0));
    chk("abort_row",   128'(out_row_o),   128'(0));
    chk("abort_valid", 128'(out_valid_o), 128'(0));
    chk("abort_idx",   128'(row_idx_o),   128'(0));
    chk("abort_busy",  128'(busy_o),      128'(0));
    chk("abort_done",  128'(done_o),      128'(0));
    rst = 1'b1;
    repeat (6) @(negedge clk);
    chk("idle_after_abort", 128'(busy_o), 128'(0));

    // Restart from row 0 with a new base
    run_block(16'h0300, 16'd2, 3'd3);
    wait_done(200);
    chk("restart_row0_px0", 128'(r0px),       128'(8'h03));
    chk("restart_done",     128'(done_cyc),   128'(76));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
